fdiv_ctrl: RTL and testbench

Multi-channel clock-divider controller for the lock design. One shared prescaler feeds NCH independent divider channels. Each channel produces a one-cycle tick strobe and a square-wave enable. Channels are configured, started and stopped through a single valid/ready command port. Consumers (keypad debounce, display scan, alarm blink, lockout timeout) use tick/wave as clock enables; no derived clocks are generated.

---
 rtl/fdiv_ctrl_pkg.sv | 20 ++
 rtl/fdiv_chan.sv | 94 +++++++++
 rtl/fdiv_ctrl.sv | 110 +++++++++++
 tb/tb_fdiv_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_ctrl_pkg.sv
// Shared definitions for the fdiv_ctrl clock-divider controller:
// command op-codes, command-port FSM states and channel-index width.
package fdiv_ctrl_pkg;

  // Command op-codes carried on cfg_op
  localparam logic [1:0] OP_SET_DIV = 2'b00;
  localparam logic [1:0] OP_START   = 2'b01;
  localparam logic [1:0] OP_STOP    = 2'b10;
  localparam logic [1:0] OP_SET_NOW = 2'b11;

  // Width of the cfg_ch channel index (up to 8 channels)
  localparam int CH_W = 3;

  // Command port: IDLE accepts, COMMIT is the one-cycle turnaround
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/fdiv_chan.sv
// One divider channel: counts prescaler ticks up to its divisor, emits a
// one-cycle tick and toggles a square wave on every wrap. A commanded
// divisor change (SET_DIV) is held in a shadow register until the next wrap.
// cmd_oneshot is tied low by the top unless FDIV_CTRL_ONESHOT_EN is defined.
module fdiv_chan
  import fdiv_ctrl_pkg::*;
#(
  parameter int            CW      = 32,
  parameter logic [CW-1:0] DIV_RST = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pre_tick,
  input  logic          cmd_en,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_div,
  input  logic          cmd_oneshot,
  output logic          tick,
  output logic          wave,
  output logic          active
);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] div_reg;
  logic [CW-1:0] shadow_reg;
  logic          pend_reg;
  logic          active_reg;
  logic          tick_reg;
  logic          wave_reg;
  logic          oneshot_reg;
  logic          wrap;

  assign wrap = active_reg && pre_tick && (cnt_reg == div_reg);

  // Channel state: START/STOP/SET_NOW override a same-cycle wrap, SET_DIV
  // lets the wrap finish with the old shadow and then re-arms the pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      div_reg     <= DIV_RST;
      shadow_reg  <= DIV_RST;
      pend_reg    <= 1'b0;
      active_reg  <= 1'b0;
      tick_reg    <= 1'b0;
      wave_reg    <= 1'b0;
      oneshot_reg <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (cmd_en && (cmd_op != OP_SET_DIV)) begin
        if (cmd_op == OP_START) begin
          div_reg     <= shadow_reg;
          cnt_reg     <= '0;
          wave_reg    <= 1'b0;
          pend_reg    <= 1'b0;
          active_reg  <= 1'b1;
          oneshot_reg <= cmd_oneshot;
        end else if (cmd_op == OP_STOP) begin
          active_reg <= 1'b0;
          wave_reg   <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          div_reg    <= cmd_div;
          shadow_reg <= cmd_div;
          cnt_reg    <= '0;
          pend_reg   <= 1'b0;
        end
      end else begin
        if (wrap) begin
          cnt_reg  <= '0;
          tick_reg <= 1'b1;
          wave_reg <= ~wave_reg;
          if (pend_reg) begin
            div_reg  <= shadow_reg;
            pend_reg <= 1'b0;
          end
          if (oneshot_reg) begin
            active_reg <= 1'b0;
          end
        end else if (active_reg && pre_tick) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        if (cmd_en) begin
          shadow_reg <= cmd_div;
          pend_reg   <= 1'b1;
        end
      end
    end
  end

  assign tick   = tick_reg;
  assign wave   = wave_reg;
  assign active = active_reg;

endmodule

// File: rtl/fdiv_ctrl.sv
// Multi-channel clock-divider controller: a shared prescaler feeds NCH
// fdiv_chan instances, configured through a valid/ready command port.
// Optional feature macro: FDIV_CTRL_ONESHOT_EN adds cfg_oneshot (sampled on
// START) so a channel can emit a single tick and then stop itself.
module fdiv_ctrl
  import fdiv_ctrl_pkg::*;
#(
  parameter int            NCH      = 4,
  parameter int            CW       = 32,
  parameter int            PRESCALE = 1,
  parameter logic [CW-1:0] DIV_RST  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [1:0]      cfg_op,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [CW-1:0]   cfg_div,
`ifdef FDIV_CTRL_ONESHOT_EN
  input  logic            cfg_oneshot,
`endif
  output logic            cfg_err,
  output logic [NCH-1:0]  tick_o,
  output logic [NCH-1:0]  wave_o,
  output logic [NCH-1:0]  active_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]  pre_cnt_reg;
  logic           pre_tick;
  fsm_state_t     state_reg;
  fsm_state_t     state_next;
  logic           accept;
  logic           cfg_ready_reg;
  logic           cfg_err_reg;
  logic           oneshot_in;
  logic [NCH-1:0] cmd_en;

`ifdef FDIV_CTRL_ONESHOT_EN
  assign oneshot_in = cfg_oneshot;
`else
  assign oneshot_in = 1'b0;
`endif

  assign pre_tick = (pre_cnt_reg == PW'(PRESCALE - 1));

  // Shared prescaler: free-running 0..PRESCALE-1, pre_tick on the last count
  always_ff @(posedge clk) begin
    if (rst || pre_tick) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + 1'b1;
    end
  end

  // Command FSM state register; cfg_ready is registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cfg_ready_reg <= 1'b1;
      cfg_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cfg_ready_reg <= (state_next == ST_IDLE);
      cfg_err_reg   <= accept && (int'(cfg_ch) >= NCH);
    end
  end

  // Command FSM next state: accept in IDLE, one dead cycle in COMMIT
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_valid) begin
          accept     = 1'b1;
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign cfg_ready = cfg_ready_reg;
  assign cfg_err   = cfg_err_reg;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign cmd_en[gi] = accept && (cfg_ch == CH_W'(gi));

    fdiv_chan #(
      .CW      (CW),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .pre_tick    (pre_tick),
      .cmd_en      (cmd_en[gi]),
      .cmd_op      (cfg_op),
      .cmd_div     (cfg_div),
      .cmd_oneshot (oneshot_in),
      .tick        (tick_o[gi]),
      .wave        (wave_o[gi]),
      .active      (active_o[gi])
    );
  end

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Scoreboard bench for fdiv_ctrl: two instances (PRESCALE=1 and PRESCALE=4)
// share one command stream. A wrap-time reference model predicts every
// cycle's outputs; a monitor pops the predictions and compares.
`timescale 1ns/1ps
module tb_fdiv_ctrl;
  import fdiv_ctrl_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int PS0 = 1;
  localparam int PS1 = 4;
`ifdef FDIV_CTRL_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic [1:0]     cfg_op;
  logic [2:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
`ifdef FDIV_CTRL_ONESHOT_EN
  logic           cfg_oneshot;
`endif
  logic           rdy0, rdy1, err0, err1;
  logic [NCH-1:0] tick0, wave0, act0, tick1, wave1, act1;

  always #5 clk = ~clk;

  fdiv_ctrl #(.NCH(NCH), .CW(CW), .PRESCALE(PS0), .DIV_RST(32'd0)) u_dut0 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy0),
    .cfg_op(cfg_op), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
`ifdef FDIV_CTRL_ONESHOT_EN
    .cfg_oneshot(cfg_oneshot),
`endif
    .cfg_err(err0), .tick_o(tick0), .wave_o(wave0), .active_o(act0));

  fdiv_ctrl #(.NCH(NCH), .CW(CW), .PRESCALE(PS1), .DIV_RST(32'd0)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
    .cfg_op(cfg_op), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
`ifdef FDIV_CTRL_ONESHOT_EN
    .cfg_oneshot(cfg_oneshot),
`endif
    .cfg_err(err1), .tick_o(tick1), .wave_o(wave1), .active_o(act1));

  typedef struct {
    int                     tag;
    logic [1:0][NCH-1:0]    tick;
    logic [1:0][NCH-1:0]    wave;
    logic [1:0][NCH-1:0]    act;
    logic                   rdy;
    logic                   err;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   drv_edges = 0;
  int   mon_edges = 0;

  // Reference model: per channel the absolute edge index of the next wrap
  longint m_div[2][NCH], m_shadow[2][NCH], m_next[2][NCH];
  bit     m_act[2][NCH], m_wave[2][NCH], m_pend[2][NCH], m_os[2][NCH];
  longint m_n;
  bit     m_ready = 1'b1;

  task automatic model_edge(input bit r, input bit v, input logic [1:0] op,
                            input logic [2:0] ch, input longint dv,
                            input bit os, output exp_t e);
    bit     acc;
    bit     here;
    longint p;
    e.tag  = 0;
    e.tick = '0;
    e.wave = '0;
    e.act  = '0;
    if (r) begin
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < NCH; c++) begin
          m_div[m][c] = 0; m_shadow[m][c] = 0; m_next[m][c] = 0;
          m_act[m][c] = 0; m_wave[m][c] = 0; m_pend[m][c] = 0; m_os[m][c] = 0;
        end
      end
      m_n     = 0;
      m_ready = 1'b1;
      e.rdy   = 1'b1;
      e.err   = 1'b0;
    end else begin
      m_n = m_n + 1;
      acc = v && m_ready;
      for (int m = 0; m < 2; m++) begin
        p = (m == 0) ? PS0 : PS1;
        for (int c = 0; c < NCH; c++) begin
          here = acc && (int'(ch) == c);
          if (here && op == OP_START) begin
            m_div[m][c]  = m_shadow[m][c];
            m_wave[m][c] = 0; m_pend[m][c] = 0; m_act[m][c] = 1; m_os[m][c] = os;
            m_next[m][c] = (m_n / p + m_div[m][c] + 1) * p;
          end else if (here && op == OP_STOP) begin
            m_act[m][c]  = 0; m_wave[m][c] = 0;
          end else if (here && op == OP_SET_NOW) begin
            m_div[m][c]  = dv; m_shadow[m][c] = dv; m_pend[m][c] = 0;
            m_next[m][c] = (m_n / p + dv + 1) * p;
          end else begin
            if (m_act[m][c] && m_n == m_next[m][c]) begin
              e.tick[m][c] = 1'b1;
              m_wave[m][c] = !m_wave[m][c];
              if (m_pend[m][c]) begin
                m_div[m][c]  = m_shadow[m][c];
                m_pend[m][c] = 0;
              end
              if (m_os[m][c]) m_act[m][c] = 0;
              m_next[m][c] = m_n + (m_div[m][c] + 1) * p;
            end
            if (here) begin
              m_shadow[m][c] = dv;
              m_pend[m][c]   = 1;
            end
          end
          e.wave[m][c] = m_wave[m][c];
          e.act[m][c]  = m_act[m][c];
        end
      end
      e.err   = acc && (int'(ch) >= NCH);
      m_ready = !acc;
      e.rdy   = m_ready;
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [1:0] op,
                      input logic [2:0] ch, input logic [CW-1:0] dv, input bit os);
    exp_t e;
    bit   os_eff;
    os_eff    = os & ONESHOT;
    rst       = r;
    cfg_valid = v;
    cfg_op    = op;
    cfg_ch    = ch;
    cfg_div   = dv;
`ifdef FDIV_CTRL_ONESHOT_EN
    cfg_oneshot = os_eff;
`endif
    if (!r && v && m_ready)
      $display("cmd edge %0d: op=%0d ch=%0d div=%0d oneshot=%0b", drv_edges + 1, op, ch, dv, os_eff);
    model_edge(r, v, op, ch, longint'(dv), os_eff, e);
    drv_edges = drv_edges + 1;
    e.tag     = drv_edges;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 2'b00, 3'd0, '0, 1'b0);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [2:0] ch,
                     input logic [CW-1:0] dv, input bit os);
    if (!m_ready) idle(1);
    step(1'b0, 1'b1, op, ch, dv, os);
  endtask

  task automatic check(input string nm, input int tag, input logic [7:0] got, input logic [7:0] want);
    n_checks = n_checks + 1;
    if (got !== want) begin
      n_errors = n_errors + 1;
      $display("FAIL %s edge %0d: got %b expected %b", nm, tag, got, want);
    end
  endtask

  always @(posedge clk) mon_edges <= mon_edges + 1;

  // Monitor: compare every predicted cycle once its edge has happened
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (expq.size() > 0 && expq[0].tag <= mon_edges) begin
        e = expq.pop_front();
        check("tick_ps1",   e.tag, 8'(tick0), 8'(e.tick[0]));
        check("wave_ps1",   e.tag, 8'(wave0), 8'(e.wave[0]));
        check("active_ps1", e.tag, 8'(act0),  8'(e.act[0]));
        check("ready_ps1",  e.tag, 8'(rdy0),  8'(e.rdy));
        check("err_ps1",    e.tag, 8'(err0),  8'(e.err));
        check("tick_ps4",   e.tag, 8'(tick1), 8'(e.tick[1]));
        check("wave_ps4",   e.tag, 8'(wave1), 8'(e.wave[1]));
        check("active_ps4", e.tag, 8'(act1),  8'(e.act[1]));
        check("ready_ps4",  e.tag, 8'(rdy1),  8'(e.rdy));
        check("err_ps4",    e.tag, 8'(err1),  8'(e.err));
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized command stream
  initial begin
    bit          r, v, os;
    logic [1:0]  op;
    logic [2:0]  ch;
    logic [31:0] dv;
    step(1'b1, 1'b0, 2'b00, 3'd0, '0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 3'd0, '0, 1'b0);
    idle(2);
    cmd(OP_SET_DIV, 3'd0, 32'd3, 1'b0);
    cmd(OP_START,   3'd0, 32'd0, 1'b0);
    idle(21);
    cmd(OP_SET_DIV, 3'd0, 32'd1, 1'b0);
    idle(12);
    cmd(OP_SET_NOW, 3'd1, 32'd0, 1'b0);
    cmd(OP_START,   3'd1, 32'd0, 1'b0);
    idle(6);
    cmd(OP_STOP,    3'd1, 32'd0, 1'b0);
    idle(3);
    cmd(OP_SET_NOW, 3'd5, 32'd9, 1'b0);
    idle(3);
    cmd(OP_START,   3'd1, 32'd0, 1'b0);
    cmd(OP_SET_NOW, 3'd3, 32'd2, 1'b0);
    cmd(OP_START,   3'd3, 32'd0, 1'b0);
    idle(5);
    step(1'b1, 1'b1, OP_START, 3'd2, '0, 1'b0);
    idle(3);
    cmd(OP_SET_NOW, 3'd2, 32'd1, 1'b0);
    cmd(OP_START,   3'd2, 32'd0, 1'b1);
    idle(30);
    cmd(OP_STOP,    3'd2, 32'd0, 1'b0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 599) == 0);
      v  = ($urandom_range(0, 2) == 0);
      op = 2'($urandom_range(0, 3));
      ch = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      dv = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 30) : $urandom_range(0, 5);
      os = ($urandom_range(0, 3) == 0);
      step(r, v, op, ch, dv, os);
    end
    idle(4);
    for (int k = 0; k < 20 && expq.size() > 0; k++) @(negedge clk);
    n_checks = n_checks + 1;
    if (expq.size() != 0) begin
      n_errors = n_errors + 1;
      $display("FAIL drain: got %0d pending predictions expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
